// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: first-word-fall-through FIFO of retired-instruction records with sequence
// stamping and overflow accounting.
// Ports:
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   commit_valid_i                one instruction retires this cycle
//   pc_i, instr_i                 PC and encoding of the retiring instruction
//   reg_addr_i, reg_data_i        destination register and written value (rd 0 = no write)
//   clear_i                       synchronous flush of FIFO, sequence and drop statistics
//   trace_valid_o, trace_ready_i  head-entry handshake
//   trace_pc_o, trace_instr_o,
//   trace_rd_addr_o,
//   trace_rd_data_o, trace_seq_o  head-entry fields, shown combinationally from storage
//   count_o                       current occupancy
//   overflow_o, drop_cnt_o        sticky drop flag and saturating drop count
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       commit_valid_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       clear_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [XLEN-1:0]            trace_pc_o,
    output logic [XLEN-1:0]            trace_instr_o,
    output logic [XLEN-1:0]            trace_rd_data_o,
    output logic [4:0]                 trace_rd_addr_o,
    output logic [15:0]                trace_seq_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o
);
    localparam int addrW = $clog2(DEPTH);
    localparam logic [addrW:0] fullCount = (addrW+1)'(DEPTH);

    logic [XLEN-1:0]  pcMem     [DEPTH];
    logic [XLEN-1:0]  instrMem  [DEPTH];
    logic [XLEN-1:0]  rdDataMem [DEPTH];
    logic [4:0]       rdAddrMem [DEPTH];
    logic [15:0]      seqMem    [DEPTH];
    logic [addrW-1:0] wrPtr;
    logic [addrW-1:0] rdPtr;
    logic [15:0]      seqCnt;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign full          = count_o == fullCount;
    assign trace_valid_o = count_o != '0;
    assign pop           = trace_valid_o && trace_ready_i;
    // A pop frees the slot the same cycle, so a full FIFO can still accept a commit.
    assign push          = commit_valid_i && (!full || pop);
    assign drop          = commit_valid_i && full && !pop;

    assign trace_pc_o      = pcMem[rdPtr];
    assign trace_instr_o   = instrMem[rdPtr];
    assign trace_rd_data_o = rdDataMem[rdPtr];
    assign trace_rd_addr_o = rdAddrMem[rdPtr];
    assign trace_seq_o     = seqMem[rdPtr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_o    <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            seqCnt     <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (clear_i) begin
            count_o    <= '0;
            wrPtr      <= '0;
            rdPtr      <= '0;
            seqCnt     <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            count_o <= (push && !pop) ? count_o + (addrW+1)'(1) :
                       (pop && !push) ? count_o - (addrW+1)'(1) : count_o;
            if (push)
                wrPtr <= wrPtr + addrW'(1);
            if (pop)
                rdPtr <= rdPtr + addrW'(1);
            // Dropped commits still consume a sequence number so gaps are visible downstream.
            if (commit_valid_i)
                seqCnt <= seqCnt + 16'd1;
            if (drop) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= (drop_cnt_o == 16'hFFFF) ? drop_cnt_o : drop_cnt_o + 16'd1;
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by count_o.
    always_ff @(posedge clk_i) begin
        if (push && !clear_i) begin
            pcMem[wrPtr]     <= pc_i;
            instrMem[wrPtr]  <= instr_i;
            rdAddrMem[wrPtr] <= reg_addr_i;
            rdDataMem[wrPtr] <= (reg_addr_i == 5'd0) ? '0 : reg_data_i;
            seqMem[wrPtr]    <= seqCnt;
        end
    end
endmodule
